// File: rtl/saturn_phase_seq.sv
// Parametrised clock-phase sequencer for the Saturn core.
// Produces one-cycle enable pulses per consumer channel, each mapped at run time
// to a phase slot. Supports bus-stall freeze, single-step rounds and a sticky
// cycle budget that halts advance.
module saturn_phase_seq #(
  parameter int unsigned PHASES   = 4,
  parameter int unsigned CHANNELS = 11,
  parameter int unsigned CTR_W    = 32,
  localparam int unsigned PHW     = $clog2(PHASES)
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_run,
  input  logic                    i_stall,
  input  logic [CHANNELS*PHW-1:0] i_ch_phase,
  input  logic [PHW-1:0]          i_cycle_phase,
  input  logic                    i_max_en,
  input  logic [CTR_W-1:0]        i_max_cycle,
  input  logic                    i_clr_halt,
  input  logic                    i_step_mode,
  input  logic                    i_step,
  output logic [CHANNELS-1:0]     o_ck_en,
  output logic [PHW-1:0]          o_phase,
  output logic [CTR_W-1:0]        o_cycle_ctr,
  output logic                    o_out_of_cycles,
  output logic                    o_idle
);

  localparam logic [PHW-1:0] PhLast   = PHW'(PHASES - 1);
  localparam logic [PHW-1:0] PhPenult = PHW'(PHASES - 2);

  logic [PHW-1:0]      phase_q, phase_d;
  logic [CHANNELS-1:0] ck_en_q, ck_en_d;
  logic [CTR_W-1:0]    cycle_ctr_q, cycle_ctr_d;
  logic                oob_q, oob_d;
  logic                step_active_q, step_active_d;
  logic                adv;
  logic                ctr_inc;

  // Advance qualifier: run, no stall, budget not exhausted, step permission.
  always_comb begin
    adv     = i_run & ~i_stall & ~oob_q & (~i_step_mode | step_active_q);
    ctr_inc = adv & (phase_q == i_cycle_phase);
  end

  // Next-state for phase, enables, counter, budget flag and step state.
  always_comb begin
    phase_d       = phase_q;
    ck_en_d       = '0;
    cycle_ctr_d   = cycle_ctr_q;
    oob_d         = oob_q;
    step_active_d = step_active_q;

    if (adv) begin
      phase_d = (phase_q == PhLast) ? '0 : phase_q + PHW'(1);
    end

    // phase_q never reaches a slot >= PHASES, so such maps never fire.
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      ck_en_d[c] = adv & (i_ch_phase[c*PHW +: PHW] == phase_q);
    end

    if (ctr_inc) begin
      cycle_ctr_d = cycle_ctr_q + CTR_W'(1);
    end

    // Clear wins over a simultaneous budget hit.
    if (i_clr_halt) begin
      oob_d = 1'b0;
    end else if (ctr_inc && i_max_en && (cycle_ctr_q == i_max_cycle)) begin
      oob_d = 1'b1;
    end

    // A round ends on the edge into the last phase; launches are held off by stall.
    if (adv && step_active_q && (phase_q == PhPenult)) begin
      step_active_d = 1'b0;
    end else if (i_step_mode && !step_active_q && i_step && !i_stall) begin
      step_active_d = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      phase_q       <= PhLast;
      ck_en_q       <= '0;
      cycle_ctr_q   <= '1;
      oob_q         <= 1'b0;
      step_active_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      ck_en_q       <= ck_en_d;
      cycle_ctr_q   <= cycle_ctr_d;
      oob_q         <= oob_d;
      step_active_q <= step_active_d;
    end
  end

  // Output mapping.
  always_comb begin
    o_ck_en         = ck_en_q;
    o_phase         = phase_q;
    o_cycle_ctr     = cycle_ctr_q;
    o_out_of_cycles = oob_q;
    o_idle          = i_step_mode & ~step_active_q;
  end

endmodule

// File: tb/tb_saturn_phase_seq.sv
// Directed bench for saturn_phase_seq: free-run, stall, budget, reset, step mode
// and a 6-phase / 3-channel instance with an out-of-range map.
module tb_saturn_phase_seq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance (PHASES=4, CHANNELS=11, CTR_W=32)
  logic        rst_n, run, stall, max_en, clr_halt, step_mode, step;
  logic [21:0] ch_phase;
  logic [1:0]  cyc_phase;
  logic [31:0] max_cycle;
  logic [10:0] ck_en;
  logic [1:0]  phase;
  logic [31:0] ctr;
  logic        oob, idle;

  saturn_phase_seq dut (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_run          (run),
    .i_stall        (stall),
    .i_ch_phase     (ch_phase),
    .i_cycle_phase  (cyc_phase),
    .i_max_en       (max_en),
    .i_max_cycle    (max_cycle),
    .i_clr_halt     (clr_halt),
    .i_step_mode    (step_mode),
    .i_step         (step),
    .o_ck_en        (ck_en),
    .o_phase        (phase),
    .o_cycle_ctr    (ctr),
    .o_out_of_cycles(oob),
    .o_idle         (idle)
  );

  // Six-phase instance, three channels mapped {0, 5, 7}
  logic        rst2_n;
  logic [8:0]  ch_phase2;
  logic [2:0]  ck_en2;
  logic [2:0]  phase2;
  logic [7:0]  ctr2;
  logic        oob2, idle2;

  saturn_phase_seq #(
    .PHASES  (6),
    .CHANNELS(3),
    .CTR_W   (8)
  ) dut6 (
    .i_clk          (clk),
    .i_reset        (rst2_n),
    .i_run          (1'b1),
    .i_stall        (1'b0),
    .i_ch_phase     (ch_phase2),
    .i_cycle_phase  (3'd0),
    .i_max_en       (1'b0),
    .i_max_cycle    (8'd0),
    .i_clr_halt     (1'b0),
    .i_step_mode    (1'b0),
    .i_step         (1'b0),
    .o_ck_en        (ck_en2),
    .o_phase        (phase2),
    .o_cycle_ctr    (ctr2),
    .o_out_of_cycles(oob2),
    .o_idle         (idle2)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Masks per slot with channel c mapped to c%4
  localparam logic [10:0] M0 = 11'h111;
  localparam logic [10:0] M1 = 11'h222;
  localparam logic [10:0] M2 = 11'h444;
  localparam logic [10:0] M3 = 11'h088;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_main(input string tag, input logic [1:0] ph, input logic [10:0] en,
                          input logic [31:0] c);
    chk({tag, "_phase"}, 64'(phase), 64'(ph));
    chk({tag, "_ck_en"}, 64'(ck_en), 64'(en));
    chk({tag, "_ctr"}, 64'(ctr), 64'(c));
  endtask

  initial begin
    rst_n     = 1'b0;
    rst2_n    = 1'b0;
    run       = 1'b1;
    stall     = 1'b0;
    max_en    = 1'b0;
    max_cycle = 32'd0;
    clr_halt  = 1'b0;
    step_mode = 1'b0;
    step      = 1'b0;
    cyc_phase = 2'd0;
    for (int c = 0; c < 11; c++) ch_phase[c*2 +: 2] = 2'(c % 4);
    ch_phase2 = {3'd7, 3'd5, 3'd0};

    repeat (2) tick();
    chk_main("reset", 2'd3, 11'h0, 32'hFFFF_FFFF);
    chk("reset_oob", 64'(oob), 64'd0);
    chk("reset_idle", 64'(idle), 64'd0);

    // Free-run
    rst_n = 1'b1;
    tick(); chk_main("fr0", 2'd0, M3, 32'hFFFF_FFFF);
    tick(); chk_main("fr1", 2'd1, M0, 32'd0);
    tick(); chk_main("fr2", 2'd2, M1, 32'd0);
    tick(); chk_main("fr3", 2'd3, M2, 32'd0);
    tick(); chk_main("fr4", 2'd0, M3, 32'd0);
    tick(); chk_main("fr5", 2'd1, M0, 32'd1);

    // Stall 3 cycles at phase 1
    stall = 1'b1;
    tick(); chk_main("st0", 2'd1, 11'h0, 32'd1);
    tick(); chk_main("st1", 2'd1, 11'h0, 32'd1);
    tick(); chk_main("st2", 2'd1, 11'h0, 32'd1);
    stall = 1'b0;
    tick(); chk_main("st3", 2'd2, M1, 32'd1);
    tick(); chk_main("st4", 2'd3, M2, 32'd1);
    tick(); chk_main("st5", 2'd0, M3, 32'd1);
    tick(); chk_main("st6", 2'd1, M0, 32'd2);

    // Budget of 5: increments to 3,4,5 then 6 sets the flag
    max_en    = 1'b1;
    max_cycle = 32'd5;
    repeat (15) tick();
    chk("bud_pre_oob", 64'(oob), 64'd0);
    tick(); chk_main("bud_set", 2'd1, M0, 32'd6);
    chk("bud_set_oob", 64'(oob), 64'd1);
    tick(); chk_main("bud_hold0", 2'd1, 11'h0, 32'd6);
    tick(); chk_main("bud_hold1", 2'd1, 11'h0, 32'd6);
    clr_halt = 1'b1;
    tick(); chk("bud_clr_oob", 64'(oob), 64'd0);
    chk_main("bud_clr", 2'd1, 11'h0, 32'd6);
    clr_halt = 1'b0;
    tick(); chk_main("bud_res0", 2'd2, M1, 32'd6);
    tick(); tick();
    tick(); chk_main("bud_res3", 2'd1, M0, 32'd7);
    max_en = 1'b0;

    // Async reset mid-round at phase 2
    tick(); chk("rst_pre_phase", 64'(phase), 64'd2);
    #3 rst_n = 1'b0;
    #1 chk_main("rst_async", 2'd3, 11'h0, 32'hFFFF_FFFF);
    chk("rst_async_oob", 64'(oob), 64'd0);
    tick(); chk_main("rst_hold", 2'd3, 11'h0, 32'hFFFF_FFFF);
    rst_n = 1'b1;
    tick(); chk_main("rr0", 2'd0, M3, 32'hFFFF_FFFF);
    tick(); chk_main("rr1", 2'd1, M0, 32'd0);

    // Step mode from reset
    rst_n     = 1'b0;
    step_mode = 1'b1;
    #1 chk("sm_rst_idle", 64'(idle), 64'd1);
    tick();
    rst_n = 1'b1;
    tick(); chk_main("sm_wait0", 2'd3, 11'h0, 32'hFFFF_FFFF);
    tick(); chk_main("sm_wait1", 2'd3, 11'h0, 32'hFFFF_FFFF);
    chk("sm_wait_idle", 64'(idle), 64'd1);
    step = 1'b1;
    tick(); chk_main("sm_launch", 2'd3, 11'h0, 32'hFFFF_FFFF);
    chk("sm_launch_idle", 64'(idle), 64'd0);
    step = 1'b0;
    tick(); chk_main("sm_r0", 2'd0, M3, 32'hFFFF_FFFF);
    step = 1'b1;
    tick(); chk_main("sm_r1", 2'd1, M0, 32'd0);
    step = 1'b0;
    tick(); chk_main("sm_r2", 2'd2, M1, 32'd0);
    tick(); chk_main("sm_r3", 2'd3, M2, 32'd0);
    chk("sm_done_idle", 64'(idle), 64'd1);
    tick(); chk_main("sm_after0", 2'd3, 11'h0, 32'd0);
    tick(); chk_main("sm_after1", 2'd3, 11'h0, 32'd0);
    step_mode = 1'b0;
    tick(); chk_main("sm_leave", 2'd0, M3, 32'd0);

    // Six-phase instance: ch1 (slot 5) then ch0 (slot 0) each round, ch2 never
    rst2_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      chk("p6_phase", 64'(phase2), 64'(i % 6));
      chk("p6_ck_en", 64'(ck_en2), (i % 6 == 0) ? 64'd2 : (i % 6 == 1) ? 64'd1 : 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
